// File: rtl/serializer_pkg.sv
// Shared types and constants for the 8-bit serializer.
// State encoding plus word and counter geometry.
package serializer_pkg;

  localparam int WORD_W = 8;
  localparam int CNT_W  = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = 3'd7;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/mod8_counter.sv
// Bit index counter for the serializer.
// Clear wins over enable; is_last flags the final bit slot.
import serializer_pkg::*;

module mod8_counter (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             is_last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign is_last = (count == CNT_LAST);

endmodule

// File: rtl/serializer_8b.sv
// 8-bit parallel-to-serial converter with valid/ready on both sides.
// Back-to-back words stream without a bubble.
import serializer_pkg::*;

module serializer_8b #(
  parameter int LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] in_8b,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              out_any
);

  state_t state;
  state_t state_nx;

  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  idx;
  logic              is_last;
  logic              in_acc;
  logic              out_acc;
  logic              sel_bit;
  logic              bit_q;

  mod8_counter u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (in_acc),
    .en      (out_acc & ~is_last),
    .count   (cnt),
    .is_last (is_last)
  );

  assign out_valid = (state == SHIFT);
  assign out_last  = out_valid & is_last;

  // Ready early on the last bit so the next word lands with no gap.
  assign in_ready = (state == IDLE)
                  | (out_valid & is_last & out_ready);

  assign in_acc  = in_valid & in_ready;
  assign out_acc = out_valid & out_ready;

  assign idx     = (LSB_FIRST != 0) ? cnt : ~cnt;
  assign sel_bit = shreg[idx];
  assign out_bit = out_valid ? sel_bit : bit_q;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (in_acc) state_nx = SHIFT;
      end
      SHIFT: begin
        if (out_acc && is_last && !in_acc) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      out_any <= 1'b0;
      bit_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (in_acc) begin
        shreg   <= in_8b;
        out_any <= |in_8b;
      end
      // Remember the presented bit so IDLE keeps showing it.
      if (out_valid) bit_q <= sel_bit;
    end
  end

endmodule

// File: tb/tb_serializer_8b.sv
// Scoreboard bench for serializer_8b, both bit orders side by side.
// Stimulus pushes expected bits; a monitor pops them on output accepts.
module tb_serializer_8b;

  typedef struct packed {
    logic b;
    logic last;
    logic any;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_8b = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;

  logic in_ready, out_bit, out_valid, out_last, out_any;
  logic in_ready_m, out_bit_m, out_valid_m, out_last_m, out_any_m;

  int   checks = 0;
  int   failures = 0;
  exp_t q_l[$];
  exp_t q_m[$];
  int   cyc = 0;
  int   acc_cnt = 0;
  int   acc_cyc[$];
  bit   toggling = 1'b0;
  bit   pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  serializer_8b #(.LSB_FIRST(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_8b     (in_8b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_any   (out_any)
  );

  serializer_8b #(.LSB_FIRST(0)) dut_m (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_8b     (in_8b),
    .in_valid  (in_valid),
    .in_ready  (in_ready_m),
    .out_bit   (out_bit_m),
    .out_valid (out_valid_m),
    .out_ready (out_ready),
    .out_last  (out_last_m),
    .out_any   (out_any_m)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic push_word(logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      q_l.push_back(exp_t'{w[i], (i == 7), |w});
      q_m.push_back(exp_t'{w[7-i], (i == 7), |w});
    end
  endtask

  // Inputs change just after the rising edge; monitor samples on falling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [7:0] w);
    int n = 0;
    in_8b = w;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("send_ready", {7'd0, in_ready}, 8'd1);
    push_word(w);
    step();
  endtask

  task automatic wait_idle();
    int n = 0;
    in_valid = 1'b0;
    do begin
      step();
      n++;
    end while (out_valid && n < 200);
    chk("idle_valid", {7'd0, out_valid}, 8'd0);
    chk("idle_ready", {6'd0, in_ready, in_ready_m}, 8'd3);
    chk("q_empty", 8'(q_l.size() + q_m.size()), 8'd0);
  endtask

  task automatic chk_reset_outs(string nm);
    chk(nm, {out_valid, out_last, out_any, out_bit,
             out_valid_m, out_last_m, out_any_m, out_bit_m}, 8'h00);
    chk({nm, "_rdy"}, {6'd0, in_ready, in_ready_m}, 8'd3);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (q_l.size() == 0) begin
          chk("lsb_extra_bit", 8'd1, 8'd0);
        end else begin
          chk("lsb_bit", {7'd0, out_bit}, {7'd0, q_l[0].b});
          chk("lsb_last", {7'd0, out_last}, {7'd0, q_l[0].last});
          chk("lsb_any", {7'd0, out_any}, {7'd0, q_l[0].any});
          if (out_ready) begin
            void'(q_l.pop_front());
            acc_cnt <= acc_cnt + 1;
            acc_cyc.push_back(cyc);
          end
        end
      end else begin
        chk("lsb_idle_last", {7'd0, out_last}, 8'd0);
      end
      if (out_valid_m) begin
        if (q_m.size() == 0) begin
          chk("msb_extra_bit", 8'd1, 8'd0);
        end else begin
          chk("msb_bit", {7'd0, out_bit_m}, {7'd0, q_m[0].b});
          chk("msb_last", {7'd0, out_last_m}, {7'd0, q_m[0].last});
          chk("msb_any", {7'd0, out_any_m}, {7'd0, q_m[0].any});
          if (out_ready) void'(q_m.pop_front());
        end
      end
    end
  end

  initial begin
    int k = 0;
    forever begin
      @(posedge clk);
      #2;
      if (toggling) begin
        out_ready = pat[k % 4];
        k++;
      end
    end
  end

  initial begin
    int a0;
    int n;

    // Reset, with a word already waiting for the first edge after release.
    in_8b = 8'hA5;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset_outs");
    push_word(8'hA5);
    rst_n = 1'b1;
    step();
    chk("first_edge_accept", {7'd0, out_valid}, 8'd1);
    wait_idle();
    chk("hold_bit", {6'd0, out_bit, out_bit_m}, 8'd3);
    chk("hold_any", {6'd0, out_any, out_any_m}, 8'd3);

    send(8'h81);
    wait_idle();

    send(8'h00);
    wait_idle();
    chk("zero_any", {6'd0, out_any, out_any_m}, 8'd0);

    // Stalled output: 1,0,0,1 ready pattern.
    a0 = acc_cnt;
    send(8'h3C);
    toggling = 1'b1;
    wait_idle();
    toggling = 1'b0;
    out_ready = 1'b1;
    chk("stall_accepts", 8'(acc_cnt - a0), 8'd8);

    // Back-to-back words; in_8b changes mid-word too.
    acc_cyc.delete();
    send(8'hF0);
    send(8'h0F);
    wait_idle();
    chk("b2b_bits", 8'(acc_cyc.size()), 8'd16);
    if (acc_cyc.size() == 16)
      chk("b2b_span", 8'(acc_cyc[15] - acc_cyc[0]), 8'd15);

    // Reset in the middle of a word.
    a0 = acc_cnt;
    send(8'hFF);
    n = 0;
    while (acc_cnt - a0 < 3 && n < 50) begin
      step();
      n++;
    end
    chk("mid_bits", 8'(acc_cnt - a0), 8'd3);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("mid_reset_outs");
    q_l.delete();
    q_m.delete();
    repeat (2) @(negedge clk);
    chk_reset_outs("mid_reset_hold");
    in_8b = 8'h01;
    in_valid = 1'b1;
    push_word(8'h01);
    rst_n = 1'b1;
    step();
    chk("restart_valid", {7'd0, out_valid}, 8'd1);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serializer_8b.md
SERIALIZER_8B -- requirements
Module: serializer_8b

Interface
REQ-001 The module SHALL have parameter LSB_FIRST, default 1: 1 = bit 0 emitted first, 0 = bit 7 emitted first.
REQ-002 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port in_8b, input, 8: parallel word to serialize.
REQ-006 Port in_valid, input, 1: in_8b holds a valid word.
REQ-007 Port in_ready, output, 1: the serializer can accept a word this cycle.
REQ-008 Port out_bit, output, 1: current serial bit.
REQ-009 Port out_valid, output, 1: out_bit is valid.
REQ-010 Port out_ready, input, 1: the downstream consumer accepts out_bit this cycle.
REQ-011 Port out_last, output, 1: out_bit is the 8th bit of the word.
REQ-012 Port out_any, output, 1: OR of all 8 bits of the word currently held.

Function
REQ-013 The module SHALL implement a 2-state FSM with states IDLE and SHIFT.
REQ-014 An input accept SHALL occur on any cycle where in_valid and in_ready are both 1.
REQ-015 An output accept SHALL occur on any cycle where out_valid and out_ready are both 1.
REQ-016 In IDLE, in_ready=1, out_valid=0, out_last=0, and out_bit SHALL hold its last value.
REQ-017 On an input accept in IDLE, the module SHALL capture in_8b into a shift register, clear the 3-bit counter to 0, load out_any with the OR of in_8b, and enter SHIFT next cycle.
REQ-018 In SHIFT, out_valid=1 and out_bit SHALL be the register bit selected by counter and LSB_FIRST; first bit valid 1 cycle after accept.
REQ-019 On an output accept in SHIFT with counter<7, the counter SHALL increment and the next bit SHALL be presented the following cycle.
REQ-020 Without an output accept, out_bit, out_last and the counter SHALL hold; no bit may be skipped or duplicated.
REQ-021 out_last SHALL be 1 exactly when in SHIFT with counter==7.
REQ-022 On an output accept with counter==7, the FSM SHALL return to IDLE, unless a simultaneous input accept occurs.
REQ-023 in_ready SHALL be 1 in IDLE, or in SHIFT when counter==7 and out_ready==1 (a combinational out_ready->in_ready path is permitted); otherwise 0.
REQ-024 An input accept during the last-bit output accept SHALL load the new word and remain in SHIFT with counter=0, giving zero-bubble back-to-back words (8 bits per 8 cycles).
REQ-025 in_8b changes while in SHIFT SHALL have no effect on the word being serialized.
REQ-026 out_any SHALL hold from capture until the next capture.

Reset
REQ-027 While rst_n=0, regardless of clk, the module SHALL force state=IDLE, counter=0, shift register=0, out_bit=0, out_valid=0, out_last=0, out_any=0, in_ready=1.
REQ-028 A reset asserted mid-word SHALL discard the partial word; after release the next word SHALL start from its first bit.
REQ-029 The first input accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-030 Package serializer_pkg SHALL hold the state enum (IDLE, SHIFT), WORD_W=8, CNT_W=3 and CNT_LAST=7.
REQ-031 The bit counter SHALL be a sub-module mod8_counter with clk, rst_n, clr, en, count[2:0] and is_last ports; all other logic stays in serializer_8b.

Verification
REQ-032 Reset then LSB_FIRST=1, word 0xA5, out_ready=1: bits 1,0,1,0,0,1,0,1 on consecutive cycles; out_last on the 8th; out_any=1; then IDLE.
REQ-033 LSB_FIRST=0, word 0x81, out_ready=1: bits 1,0,0,0,0,0,0,1.
REQ-034 Word 0x00: all 8 bits 0; out_any=0; out_last on the 8th bit only.
REQ-035 Word 0x3C with out_ready toggled 1,0,0,1,...: each bit held while out_ready=0; sequence 0,0,1,1,1,1,0,0 is intact; 8 output accepts exactly.
REQ-036 Words 0xF0 then 0x0F with in_valid held high: in_ready pulses with the last bit; 16 bits in 16 cycles with no gap; out_last on bits 8 and 16.
REQ-037 Reset after 3 bits of 0xFF, then word 0x01: out_valid=0 during reset; then bits 1,0,0,0,0,0,0,0 from counter 0.
